// File: rtl/video_timing_gen.sv
// Raster timing source for the TMDS encoders: scans a parameterised frame and
// produces pixel coordinates plus blanking/sync delayed to match the pixel pipeline.
module video_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int LATENCY   = 1
) (
    input  logic        pix_clock,
    input  logic        reset,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        active,
    output logic        line_start,
    output logic        frame_start,
    output logic        blanking,
    output logic [1:0]  control_data
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > 4096 || V_TOTAL > 4096 || LATENCY < 0 || LATENCY > 15) begin : g_bad_params
            $error("video_timing_gen: frame totals must be <= 4096 and LATENCY in 0..15");
        end
    endgenerate

    // Comparisons use 13 bits so a 4096-wide frame still has representable bounds.
    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
    localparam logic [12:0] H_ACT_E  = 13'(H_ACTIVE);
    localparam logic [12:0] V_ACT_E  = 13'(V_ACTIVE);
    localparam logic [12:0] H_SYN_S  = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] H_SYN_E  = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [12:0] V_SYN_S  = 13'(V_ACTIVE + V_FP);
    localparam logic [12:0] V_SYN_E  = 13'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [2:0]  PIPE_RST = {1'b1, ~VSYNC_POL, ~HSYNC_POL};

    logic [11:0] h_cnt_r;
    logic [11:0] v_cnt_r;
    logic [12:0] h_ext_s;
    logic [12:0] v_ext_s;
    logic        active_s;
    logic        hsync_raw_s;
    logic        vsync_raw_s;
    logic [2:0]  pipe_in_s;
    logic [2:0]  pipe_out_s;

    // Horizontal/vertical raster counters; both wrap on the same edge at frame end.
    always_ff @(posedge pix_clock) begin
        if (reset) begin
            h_cnt_r <= 12'd0;
            v_cnt_r <= 12'd0;
        end else if (h_cnt_r == H_LAST) begin
            h_cnt_r <= 12'd0;
            if (v_cnt_r == V_LAST) begin
                v_cnt_r <= 12'd0;
            end else begin
                v_cnt_r <= v_cnt_r + 12'd1;
            end
        end else begin
            h_cnt_r <= h_cnt_r + 12'd1;
        end
    end

    // Region decode straight from the counters (zero latency).
    always_comb begin
        h_ext_s  = {1'b0, h_cnt_r};
        v_ext_s  = {1'b0, v_cnt_r};
        active_s = (h_ext_s < H_ACT_E) && (v_ext_s < V_ACT_E);
        if ((h_ext_s >= H_SYN_S) && (h_ext_s < H_SYN_E)) begin
            hsync_raw_s = HSYNC_POL;
        end else begin
            hsync_raw_s = ~HSYNC_POL;
        end
        if ((v_ext_s >= V_SYN_S) && (v_ext_s < V_SYN_E)) begin
            vsync_raw_s = VSYNC_POL;
        end else begin
            vsync_raw_s = ~VSYNC_POL;
        end
        pipe_in_s = {~active_s, vsync_raw_s, hsync_raw_s};
    end

    generate
        if (LATENCY == 0) begin : g_pass
            assign pipe_out_s = pipe_in_s;
        end else begin : g_pipe
            logic [2:0] pipe_r [LATENCY];

            // Delay line aligning blanking/syncs with the pipelined pixel source.
            always_ff @(posedge pix_clock) begin
                if (reset) begin
                    for (int i = 0; i < LATENCY; i++) begin
                        pipe_r[i] <= PIPE_RST;
                    end
                end else begin
                    pipe_r[0] <= pipe_in_s;
                    for (int i = 1; i < LATENCY; i++) begin
                        pipe_r[i] <= pipe_r[i-1];
                    end
                end
            end

            assign pipe_out_s = pipe_r[LATENCY-1];
        end
    endgenerate

    assign x            = h_cnt_r;
    assign y            = v_cnt_r;
    assign active       = active_s;
    assign line_start   = ~reset & (h_cnt_r == 12'd0);
    assign frame_start  = ~reset & (h_cnt_r == 12'd0) & (v_cnt_r == 12'd0);
    assign blanking     = pipe_out_s[2];
    assign control_data = pipe_out_s[1:0];

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen: four builds (default timing plus small
// frames with LATENCY 0/4 and inverted hsync polarity) under a shared reset.
module tb_video_timing_gen;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic        active;
        logic        line_start;
        logic        frame_start;
        logic        blanking;
        logic [1:0]  control_data;
    } obs_t;

    typedef obs_t [3:0] obs4_t;

    localparam int SH_A = 16, SH_F = 2, SH_S = 3, SH_B = 4;
    localparam int SV_A = 6,  SV_F = 1, SV_S = 2, SV_B = 2;

    // Per build: h_active, h_fp, h_sync, h_bp, v_active, v_fp, v_sync, v_bp, hpol, vpol, latency
    localparam int PRM [4][11] = '{
        '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 1},
        '{SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B, 0, 0, 0},
        '{SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B, 0, 0, 4},
        '{SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B, 1, 0, 2}
    };

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] xs [4];
    logic [11:0] ys [4];
    logic        acts [4];
    logic        lss [4];
    logic        fss [4];
    logic        blks [4];
    logic [1:0]  cds [4];

    int    tests = 0;
    int    fails = 0;
    obs4_t exp_q [$];

    always #5 clk = ~clk;

    video_timing_gen u_def (
        .pix_clock(clk), .reset(reset), .x(xs[0]), .y(ys[0]), .active(acts[0]),
        .line_start(lss[0]), .frame_start(fss[0]), .blanking(blks[0]), .control_data(cds[0])
    );

    video_timing_gen #(
        .H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
        .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .LATENCY(0)
    ) u_l0 (
        .pix_clock(clk), .reset(reset), .x(xs[1]), .y(ys[1]), .active(acts[1]),
        .line_start(lss[1]), .frame_start(fss[1]), .blanking(blks[1]), .control_data(cds[1])
    );

    video_timing_gen #(
        .H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
        .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .LATENCY(4)
    ) u_l4 (
        .pix_clock(clk), .reset(reset), .x(xs[2]), .y(ys[2]), .active(acts[2]),
        .line_start(lss[2]), .frame_start(fss[2]), .blanking(blks[2]), .control_data(cds[2])
    );

    video_timing_gen #(
        .H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
        .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .LATENCY(2)
    ) u_hp (
        .pix_clock(clk), .reset(reset), .x(xs[3]), .y(ys[3]), .active(acts[3]),
        .line_start(lss[3]), .frame_start(fss[3]), .blanking(blks[3]), .control_data(cds[3])
    );

    // Reference: n = cycles since the last reset edge; position is n modulo the frame,
    // delayed outputs are the undelayed rule evaluated LATENCY cycles earlier.
    function automatic obs_t ref_model(input int i, input int n, input bit rst);
        obs_t e;
        int ht, vt, p, h, v, q, qh, qv, hs0, vs0;
        bit hpol, vpol, hon, von;
        ht   = PRM[i][0] + PRM[i][1] + PRM[i][2] + PRM[i][3];
        vt   = PRM[i][4] + PRM[i][5] + PRM[i][6] + PRM[i][7];
        hpol = (PRM[i][8] != 0);
        vpol = (PRM[i][9] != 0);
        hs0  = PRM[i][0] + PRM[i][1];
        vs0  = PRM[i][4] + PRM[i][5];
        p = n % (ht * vt);
        h = p % ht;
        v = p / ht;
        e.x            = 12'(h);
        e.y            = 12'(v);
        e.active       = (h < PRM[i][0]) && (v < PRM[i][4]);
        e.line_start   = !rst && (h == 0);
        e.frame_start  = !rst && (p == 0);
        if (n >= PRM[i][10]) begin
            q   = (n - PRM[i][10]) % (ht * vt);
            qh  = q % ht;
            qv  = q / ht;
            hon = (qh >= hs0) && (qh < hs0 + PRM[i][2]);
            von = (qv >= vs0) && (qv < vs0 + PRM[i][6]);
            e.blanking        = !((qh < PRM[i][0]) && (qv < PRM[i][4]));
            e.control_data[0] = hon ? hpol : !hpol;
            e.control_data[1] = von ? vpol : !vpol;
        end else begin
            e.blanking     = 1'b1;
            e.control_data = {!vpol, !hpol};
        end
        return e;
    endfunction

    function automatic obs_t observe(input int i);
        obs_t o;
        o.x            = xs[i];
        o.y            = ys[i];
        o.active       = acts[i];
        o.line_start   = lss[i];
        o.frame_start  = fss[i];
        o.blanking     = blks[i];
        o.control_data = cds[i];
        return o;
    endfunction

    int n_cyc = 0;

    // One clock: advance the model, set reset for this cycle, queue expectations.
    task automatic step(input bit next_rst);
        obs4_t e;
        @(posedge clk);
        #1;
        if (reset) n_cyc = 0;
        else       n_cyc = n_cyc + 1;
        reset = next_rst;
        for (int i = 0; i < 4; i++) e[i] = ref_model(i, n_cyc, next_rst);
        exp_q.push_back(e);
    endtask

    // Monitor: outputs are sampled on the falling edge, away from the active edge.
    initial begin
        obs4_t e;
        obs_t  a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int i = 0; i < 4; i++) begin
                    a = observe(i);
                    tests++;
                    if (a !== e[i]) begin
                        fails++;
                        if (fails <= 20)
                            $display("FAIL inst%0d t=%0t got x=%0d y=%0d act=%b ls=%b fs=%b blk=%b cd=%b expected x=%0d y=%0d act=%b ls=%b fs=%b blk=%b cd=%b",
                                     i, $time, a.x, a.y, a.active, a.line_start, a.frame_start, a.blanking, a.control_data,
                                     e[i].x, e[i].y, e[i].active, e[i].line_start, e[i].frame_start, e[i].blanking, e[i].control_data);
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        repeat (2) step(1'b1);
        // Release, run to line 10 x=700 of the default build (mid-hsync), reset there.
        repeat (8701) step(1'b0);
        repeat (3) step(1'b1);
        repeat (1500) step(1'b0);
        // Random short resets sprinkled over continued free-running.
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 299) == 0) begin
                repeat ($urandom_range(1, 4)) step(1'b1);
            end else begin
                step(1'b0);
            end
        end
        repeat (3) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
